db_arbiter: RTL and testbench

- Two-master arbiter for the single memory data bus (addr / dataOut / dataIn / accessType / ready).
- Master 0 is the CPU core; master 1 is a secondary bus master (DMA or debug loader). The slave side drives the memory or MMU.
- Round-robin grant, changed only at transfer boundaries, with a per-owner burst limit and a ready-timeout abort.

---
 rtl/db_arbiter.sv | 167 ++++++++++++++++
 tb/tb_db_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db_arbiter.sv
// Two-master round-robin arbiter for the shared memory data bus. The grant moves
// only at transfer boundaries, with a per-owner burst limit and a slave ready-timeout abort.
module db_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic [1:0]  m0_accessType,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dataOut,
  output logic        m0_ready,
  output logic        m0_err,
  output logic [31:0] m0_dataIn,
  input  logic [1:0]  m1_accessType,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dataOut,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] m1_dataIn,
  output logic [1:0]  s_accessType,
  output logic [31:0] s_addr,
  output logic [31:0] s_dataOut,
  input  logic        s_ready,
  input  logic [31:0] s_dataIn,
  output logic [1:0]  grant
);

  localparam int unsigned BEAT_W = 8;
  localparam int unsigned TO_W   = 16;
  localparam logic [1:0]        ACC_NONE  = 2'b00;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [BEAT_W:0]   BURST_LIM = (BEAT_W + 1)'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          grant_q, grant_d;

  logic                req0, req1;
  logic                own_req, oth_req, cmpl;
  state_e              oth_state;
  logic [BEAT_W:0]     beat_inc;

  assign req0 = (m0_accessType != ACC_NONE);
  assign req1 = (m1_accessType != ACC_NONE);

  // Tie-break: when both request, the master that did not own last wins.
  function automatic state_e arbitrate(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? ST_OWN0 : ST_OWN1;
    else if (r0)  return ST_OWN0;
    else if (r1)  return ST_OWN1;
    else          return ST_IDLE;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      beat_q  <= '0;
      to_q    <= '0;
      err_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      err_q   <= err_d;
      grant_q <= grant_d;
    end
  end

  // Next-state, burst and timeout bookkeeping
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    beat_d    = beat_q;
    to_d      = to_q;
    err_d     = '0;
    own_req   = 1'b0;
    oth_req   = 1'b0;
    oth_state = ST_IDLE;
    beat_inc  = {1'b0, beat_q} + (BEAT_W + 1)'(1);

    unique case (state_q)
      ST_OWN0: begin
        own_req   = req0;
        oth_req   = req1;
        oth_state = ST_OWN1;
      end
      ST_OWN1: begin
        own_req   = req1;
        oth_req   = req0;
        oth_state = ST_OWN0;
      end
      default: begin
      end
    endcase
    cmpl = own_req && s_ready;

    if (state_q == ST_IDLE || !own_req) begin
      state_d = arbitrate(req0, req1, last_q);
    end else if (cmpl) begin
      if (beat_inc < BURST_LIM || !oth_req) state_d = state_q;
      else                                   state_d = oth_state;
    end else if (to_q == TO_LAST) begin
      // Completion above takes priority, so an abort never coincides with ready.
      state_d = oth_req ? oth_state : ST_IDLE;
      err_d   = (state_q == ST_OWN0) ? 2'b01 : 2'b10;
    end

    if (state_d == ST_IDLE || state_d != state_q) begin
      beat_d = '0;
      to_d   = '0;
    end else if (cmpl) begin
      beat_d = (beat_q == '1) ? beat_q : beat_inc[BEAT_W-1:0];
      to_d   = '0;
    end else if (own_req) begin
      to_d = to_q + TO_W'(1);
    end

    if (state_d != state_q && state_d != ST_IDLE) last_d = (state_d == ST_OWN1);
    grant_d = {state_d == ST_OWN1, state_d == ST_OWN0};
  end

  // Slave mux and per-master ready, decoded from the current owner
  always_comb begin
    s_accessType = ACC_NONE;
    s_addr       = '0;
    s_dataOut    = '0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    unique case (state_q)
      ST_OWN0: begin
        s_accessType = m0_accessType;
        s_addr       = m0_addr;
        s_dataOut    = m0_dataOut;
        m0_ready     = s_ready && req0;
      end
      ST_OWN1: begin
        s_accessType = m1_accessType;
        s_addr       = m1_addr;
        s_dataOut    = m1_dataOut;
        m1_ready     = s_ready && req1;
      end
      default: begin
      end
    endcase
  end

  assign grant     = grant_q;
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_dataIn = s_dataIn;
  assign m1_dataIn = s_dataIn;

endmodule

// File: tb/tb_db_arbiter.sv
// Directed bench for db_arbiter: per-master transaction queues, a scoreboard of issued
// transfers checked at each completion, and an expected owner order.
module tb_db_arbiter;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_R    = 2'b01;
  localparam logic [1:0] ACC_W    = 2'b10;

  typedef struct packed {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        res;
  logic [1:0]  mt0, mt1;
  logic [31:0] ma0, ma1, md0, md1;
  logic        rdy0, rdy1, err0, err1;
  logic [31:0] din0, din1;
  logic [1:0]  s_accessType;
  logic [31:0] s_addr, s_dataOut;
  logic        s_ready;
  logic [31:0] s_dataIn = 32'h0;
  logic [1:0]  grant;

  db_arbiter #(.MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .res(res),
    .m0_accessType(mt0), .m0_addr(ma0), .m0_dataOut(md0),
    .m0_ready(rdy0), .m0_err(err0), .m0_dataIn(din0),
    .m1_accessType(mt1), .m1_addr(ma1), .m1_dataOut(md1),
    .m1_ready(rdy1), .m1_err(err1), .m1_dataIn(din1),
    .s_accessType(s_accessType), .s_addr(s_addr), .s_dataOut(s_dataOut),
    .s_ready(s_ready), .s_dataIn(s_dataIn), .grant(grant)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0, cyc = 0;
  txn_t pq0[$], pq1[$], sb0[$], sb1[$];
  int   exp_own[$], cc0[$], cc1[$];
  logic act0, act1;
  logic [1:0]  g_s, st_s;
  logic        c0_s, c1_s, rd_pend, rd_next, slv_hit;
  logic [31:0] exp_rd, slv_addr;
  int   n_rdy0, n_rdy1, n_err0, n_err1, err_cyc, kg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
  endtask

  function automatic txn_t mk(input logic [1:0] typ, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.typ = typ; t.addr = addr; t.data = data;
    return t;
  endfunction

  task automatic drv(input int i, input txn_t t);
    if (i == 0) begin mt0 = t.typ; ma0 = t.addr; md0 = t.data; act0 = 1'b1; end
    else        begin mt1 = t.typ; ma1 = t.addr; md1 = t.data; act1 = 1'b1; end
  endtask

  task automatic drop(input int i);
    if (i == 0) begin mt0 = ACC_NONE; ma0 = '0; md0 = '0; act0 = 1'b0; end
    else        begin mt1 = ACC_NONE; ma1 = '0; md1 = '0; act1 = 1'b0; end
  endtask

  // Issue the next queued transaction of each idle master and record it on the scoreboard.
  task automatic service();
    txn_t t;
    if (!act0 && pq0.size() > 0) begin t = pq0.pop_front(); sb0.push_back(t); drv(0, t); end
    if (!act1 && pq1.size() > 0) begin t = pq1.pop_front(); sb1.push_back(t); drv(1, t); end
  endtask

  task automatic complete(input int i, input txn_t t);
    int e;
    chk("s_addr", s_addr, t.addr);
    chk("s_accessType", 32'(s_accessType), 32'(t.typ));
    if (t.typ == ACC_W) chk("s_dataOut", s_dataOut, t.data);
    else begin rd_next = 1'b1; exp_rd = t.addr >> 4; end
    e = -1;
    if (exp_own.size() > 0) e = exp_own.pop_front();
    chk("owner_order", 32'(i), 32'(e));
  endtask

  // One clock: sample and check at the falling edge, advance masters/slave after the rising edge.
  task automatic step();
    txn_t t;
    @(negedge clk);
    cyc++;
    g_s = grant; c0_s = rdy0; c1_s = rdy1; st_s = s_accessType;
    rd_next = 1'b0;
    if (rd_pend) begin
      chk("m0_dataIn", din0, exp_rd);
      chk("m1_dataIn", din1, exp_rd);
    end
    chk("ready_only_owner", 32'({c1_s & ~g_s[1], c0_s & ~g_s[0]}), 32'd0);
    slv_hit = s_ready && (s_accessType != ACC_NONE);
    slv_addr = s_addr;
    if (c0_s) begin
      n_rdy0++; cc0.push_back(cyc);
      chk("sb0_pending", 32'(sb0.size() > 0), 32'd1);
      if (sb0.size() > 0) begin t = sb0.pop_front(); complete(0, t); end
    end
    if (c1_s) begin
      n_rdy1++; cc1.push_back(cyc);
      chk("sb1_pending", 32'(sb1.size() > 0), 32'd1);
      if (sb1.size() > 0) begin t = sb1.pop_front(); complete(1, t); end
    end
    if (err0) begin n_err0++; err_cyc = cyc; if (sb0.size() > 0) t = sb0.pop_front(); drop(0); end
    if (err1) begin n_err1++; err_cyc = cyc; if (sb1.size() > 0) t = sb1.pop_front(); drop(1); end
    @(posedge clk);
    #1;
    if (c0_s) drop(0);
    if (c1_s) drop(1);
    if (slv_hit) s_dataIn = slv_addr >> 4;
    rd_pend = rd_next;
    service();
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g, input int budget);
    int k = 0;
    do begin step(); k++; end while (g_s !== g && k < budget);
    chk(tag, 32'(g_s), 32'(g));
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int k = 0;
    while ((exp_own.size() > 0 || sb0.size() > 0 || sb1.size() > 0) && k < budget) begin
      step(); k++;
    end
    chk(tag, 32'(exp_own.size() + sb0.size() + sb1.size()), 32'd0);
  endtask

  task automatic do_reset();
    res = 1'b1; s_ready = 1'b0;
    drop(0); drop(1);
    pq0.delete(); pq1.delete(); sb0.delete(); sb1.delete();
    exp_own.delete(); cc0.delete(); cc1.delete();
    rd_pend = 1'b0; n_rdy0 = 0; n_rdy1 = 0; n_err0 = 0; n_err1 = 0; err_cyc = 0;
    step(); step();
    res = 1'b0;
  endtask

  task automatic run_timeout(input bit other);
    do_reset();
    pq0.push_back(mk(ACC_W, 32'h4C, 32'hDEAD_BEEF));
    if (other) begin pq1.push_back(mk(ACC_R, 32'h500, 32'h0)); exp_own.push_back(1); end
    service();
    wait_grant("D_grant_m0", 2'b01, 5);
    kg = cyc;
    for (int k = 0; k < 30 && n_err0 == 0; k++) step();
    chk("D_err_latency", 32'(err_cyc - kg), 32'd16);
    chk("D_grant_after_abort", 32'(g_s), other ? 32'd2 : 32'd0);
    repeat (3) step();
    chk("D_err_once", 32'(n_err0), 32'd1);
    chk("D_no_ready", 32'(n_rdy0), 32'd0);
    if (other) begin
      s_ready = 1'b1;
      run_until_done("D_m1_served", 10);
    end else begin
      chk("D_stays_idle", 32'(g_s), 32'd0);
    end
  endtask

  initial begin
    res = 1'b1; s_ready = 1'b0;
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_accessType", 32'(s_accessType), 32'd0);
    chk("rst_ready_err", 32'({rdy0, rdy1, err0, err1}), 32'd0);

    // Single read by m0 with an always-ready slave
    s_ready = 1'b1;
    pq0.push_back(mk(ACC_R, 32'h40, 32'h0)); exp_own.push_back(0);
    service();
    step(); chk("A_idle_before", 32'(g_s), 32'd0);
    step(); chk("A_grant", 32'(g_s), 32'd1); chk("A_ready", 32'(c0_s), 32'd1);
    step(); chk("A_ready_pulse", 32'(n_rdy0), 32'd1);
    step(); chk("A_release", 32'(g_s), 32'd0);

    // Both continuous: bursts of four alternate, no bubble at the switch
    do_reset(); s_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pq0.push_back(mk(ACC_R, 32'h100 + 32'(k * 16), 32'h0));
      pq1.push_back(mk(ACC_W, 32'h200 + 32'(k * 16), 32'hA000 + 32'(k)));
    end
    for (int k = 0; k < 16; k++) exp_own.push_back((k / 4) % 2);
    service();
    run_until_done("B_all_done", 40);
    chk("B_back_to_back", 32'(cc1[7] - cc0[0]), 32'd15);

    // m0 alone keeps the grant; m1 arrives at beat 6 and wins after the 7th completion
    do_reset(); s_ready = 1'b1;
    for (int k = 0; k < 10; k++) pq0.push_back(mk(ACC_W, 32'h1000 + 32'(k * 4), 32'h5500 + 32'(k)));
    for (int k = 0; k < 7; k++) exp_own.push_back(0);
    exp_own.push_back(1);
    for (int k = 0; k < 3; k++) exp_own.push_back(0);
    service();
    for (int k = 0; k < 20 && n_rdy0 < 6; k++) step();
    chk("C_six_beats", 32'(n_rdy0), 32'd6);
    pq1.push_back(mk(ACC_R, 32'h300, 32'h0));
    service();
    run_until_done("C_all_done", 30);
    chk("C_switch_no_bubble", 32'(cc1[0] - cc0[6]), 32'd1);

    // Ready-timeout abort, with and without a waiting second master
    run_timeout(1'b0);
    run_timeout(1'b1);

    // Ready arriving on the expiry edge completes instead of aborting
    do_reset();
    pq0.push_back(mk(ACC_W, 32'h4C, 32'h1234_5678)); exp_own.push_back(0);
    service();
    wait_grant("E_grant_m0", 2'b01, 5);
    repeat (14) step();
    s_ready = 1'b1;
    step(); chk("E_ready_at_expiry", 32'(c0_s), 32'd1);
    step(); chk("E_no_err", 32'(n_err0), 32'd0);
    chk("E_one_ready", 32'(n_rdy0), 32'd1);

    // Reset while m1 owns mid-transfer; afterwards m0 wins the first tie
    do_reset();
    pq1.push_back(mk(ACC_R, 32'h600, 32'h0));
    service();
    wait_grant("F_grant_m1", 2'b10, 5);
    step();
    res = 1'b1;
    step(); step();
    chk("F_rst_grant", 32'(g_s), 32'd0);
    chk("F_rst_s_accessType", 32'(st_s), 32'd0);
    chk("F_rst_m1_ready", 32'(c1_s), 32'd0);
    drop(1); sb1.delete(); exp_own.delete();
    res = 1'b0; s_ready = 1'b1;
    pq0.push_back(mk(ACC_R, 32'h700, 32'h0));
    pq1.push_back(mk(ACC_R, 32'h600, 32'h0));
    exp_own.push_back(0); exp_own.push_back(1);
    service();
    run_until_done("F_reissue_done", 10);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
